// File: rtl/joypad_pkg.sv
// Shared definitions for the joypad poller: FSM encoding, default timing
// constants, button bit positions and edge-mask helpers.
package joypad_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_BUSY  = 2'd2
   } state_t;

   // 60 Hz polling at 50 MHz, generous transaction timeout
   localparam int DEF_POLL_PERIOD = 833_333;
   localparam int DEF_TIMEOUT     = 2_000_000;
   localparam int DEF_FAIL_LIMIT  = 3;

   // Bit positions in the bridge's joypad byte (first bit shifted out at MSB)
   localparam int BTN_A      = 7;
   localparam int BTN_B      = 6;
   localparam int BTN_SELECT = 5;
   localparam int BTN_START  = 4;
   localparam int BTN_UP     = 3;
   localparam int BTN_DOWN   = 2;
   localparam int BTN_LEFT   = 1;
   localparam int BTN_RIGHT  = 0;

   // Buttons that went from released to held
   function automatic logic [7:0] rise_mask(input logic [7:0] old_b, input logic [7:0] new_b);
      return new_b & ~old_b;
   endfunction

   // Buttons that went from held to released
   function automatic logic [7:0] fall_mask(input logic [7:0] old_b, input logic [7:0] new_b);
      return old_b & ~new_b;
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running period counter; emits a one-cycle tick on wrap while enabled.
module tick_gen
   import joypad_pkg::*;
#(
   parameter int PERIOD = DEF_POLL_PERIOD
)(
   input  logic clk,
   input  logic rst,
   input  logic enable,
   output logic tick
);

   localparam int CW = $clog2(PERIOD + 1);

   logic [CW-1:0] cnt;

   assign tick = enable && (cnt == CW'(PERIOD - 1));

   // Count 0..PERIOD-1; disabled holds the count at zero so re-enable starts a full period
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (!enable || tick)
         cnt <= '0;
      else
         cnt <= cnt + CW'(1);
   end

endmodule

// File: rtl/joypad_poller.sv
// Fixed-rate poll scheduler for the NES controller bridge: one transaction
// per period, timeout supervision, debounced connect state and edge masks.
module joypad_poller
   import joypad_pkg::*;
#(
   parameter int POLL_PERIOD = DEF_POLL_PERIOD,
   parameter int TIMEOUT     = DEF_TIMEOUT,
   parameter int FAIL_LIMIT  = DEF_FAIL_LIMIT
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   output logic       bridge_start,
   input  logic       bridge_ready,
   input  logic [7:0] bridge_joypad,
   input  logic       bridge_valid,
   output logic [7:0] buttons,
   output logic [7:0] pressed,
   output logic [7:0] released,
   output logic       update,
   output logic       connected
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int FW = $clog2(FAIL_LIMIT + 1);

   state_t        state;
   logic          tick;
   logic          pending;
   logic          seen_busy;
   logic [TW-1:0] to_cnt;
   logic [FW-1:0] fail_cnt;
   logic          complete;
   logic          timed_out;
   logic          poll_ok;
   logic          poll_fail;

   tick_gen #(.PERIOD(POLL_PERIOD)) u_tick (
      .clk    (clk),
      .rst    (rst),
      .enable (enable),
      .tick   (tick)
   );

   // Start only while the bridge is idle; a dropped enable cancels an unissued poll
   assign bridge_start = (state == ST_ISSUE) && bridge_ready && enable;

   // Completion needs the bridge to have gone busy first, so the ready level
   // seen right after start is not mistaken for the end of the transaction
   assign complete  = (state == ST_BUSY) && seen_busy && bridge_ready;
   assign timed_out = (state == ST_BUSY) && !complete && (to_cnt == TW'(TIMEOUT - 1));
   assign poll_ok   = complete && bridge_valid;
   assign poll_fail = (complete && !bridge_valid) || timed_out;

   // Poll request latch; extra ticks while one is waiting collapse into it
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         pending <= 1'b0;
      else if (!enable)
         pending <= 1'b0;
      else if (tick)
         pending <= 1'b1;
      else if (bridge_start)
         pending <= 1'b0;
   end

   // Transaction FSM plus registered result outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         seen_busy <= 1'b0;
         to_cnt    <= '0;
         fail_cnt  <= '0;
         buttons   <= '0;
         pressed   <= '0;
         released  <= '0;
         update    <= 1'b0;
         connected <= 1'b0;
      end else begin
         pressed  <= '0;
         released <= '0;
         update   <= 1'b0;

         unique case (state)
            ST_IDLE: begin
               if (pending)
                  state <= ST_ISSUE;
            end
            ST_ISSUE: begin
               if (!enable) begin
                  state <= ST_IDLE;
               end else if (bridge_ready) begin
                  state     <= ST_BUSY;
                  to_cnt    <= '0;
                  seen_busy <= 1'b0;
               end
            end
            ST_BUSY: begin
               if (!bridge_ready)
                  seen_busy <= 1'b1;
               if (to_cnt != TW'(TIMEOUT))
                  to_cnt <= to_cnt + TW'(1);
               if (complete || timed_out)
                  state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase

         if (poll_ok) begin
            buttons   <= bridge_joypad;
            pressed   <= rise_mask(buttons, bridge_joypad);
            released  <= fall_mask(buttons, bridge_joypad);
            update    <= 1'b1;
            fail_cnt  <= '0;
            connected <= 1'b1;
         end else if (poll_fail && (fail_cnt != FW'(FAIL_LIMIT))) begin
            fail_cnt <= fail_cnt + FW'(1);
            // Only the fail that reaches the limit disconnects and reports
            if (fail_cnt == FW'(FAIL_LIMIT - 1)) begin
               connected <= 1'b0;
               released  <= buttons;
               buttons   <= '0;
               update    <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_joypad_poller.sv
// Directed bench for joypad_poller with a behavioural bridge model.
module tb_joypad_poller;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b1;
   logic       bridge_start;
   logic       bridge_ready;
   logic [7:0] bridge_joypad;
   logic       bridge_valid;
   logic [7:0] buttons;
   logic [7:0] pressed;
   logic [7:0] released;
   logic       update;
   logic       connected;

   int tests = 0;
   int fails = 0;
   int cyc;
   int at;
   int e;

   // bridge model controls
   int         m_delay = 20;
   logic       m_valid = 1'b1;
   logic [7:0] m_data  = 8'h81;
   int         b_cnt;

   joypad_poller #(.POLL_PERIOD(100), .TIMEOUT(50), .FAIL_LIMIT(3)) dut (
      .clk           (clk),
      .rst           (rst),
      .enable        (enable),
      .bridge_start  (bridge_start),
      .bridge_ready  (bridge_ready),
      .bridge_joypad (bridge_joypad),
      .bridge_valid  (bridge_valid),
      .buttons       (buttons),
      .pressed       (pressed),
      .released      (released),
      .update        (update),
      .connected     (connected)
   );

   always #5 clk = ~clk;

   // cycle index since reset release
   always @(posedge clk or posedge rst)
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;

   // bridge: ready drops the cycle after start, returns m_delay cycles after start
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         bridge_ready  <= 1'b1;
         bridge_valid  <= 1'b0;
         bridge_joypad <= 8'h00;
         b_cnt         <= 0;
      end else if (bridge_start) begin
         bridge_ready <= 1'b0;
         bridge_valid <= 1'b0;
         b_cnt        <= 1;
      end else if (b_cnt != 0) begin
         if (b_cnt == m_delay - 1) begin
            bridge_ready  <= 1'b1;
            bridge_valid  <= m_valid;
            bridge_joypad <= m_data;
            b_cnt         <= 0;
         end else begin
            b_cnt <= b_cnt + 1;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   // wait up to budget negedges for start (upd=0) or update (upd=1); res=-1 if none
   task automatic wait_sig(input bit upd, input int budget, output int res);
      res = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if ((upd ? update : bridge_start) === 1'b1) begin
            res = cyc;
            break;
         end
      end
   endtask

   task automatic check_outs(input string tag, input logic [7:0] b, input logic [7:0] p,
                             input logic [7:0] r, input logic c);
      check({tag, ".buttons"},   32'(buttons),   32'(b));
      check({tag, ".pressed"},   32'(pressed),   32'(p));
      check({tag, ".released"},  32'(released),  32'(r));
      check({tag, ".connected"}, 32'(connected), 32'(c));
   endtask

   initial begin
      // reset state
      repeat (3) @(negedge clk);
      check_outs("rst", 8'h00, 8'h00, 8'h00, 1'b0);
      check("rst.update", 32'(update), 32'd0);
      check("rst.start", 32'(bridge_start), 32'd0);
      rst = 1'b0;

      // first poll: tick at 99, start at 101, update 21 later
      wait_sig(0, 150, at);  check("p1.start_cyc", at, 101);
      @(negedge clk);        check("p1.start_1cyc", 32'(bridge_start), 32'd0);
      wait_sig(1, 40, at);   check("p1.upd_cyc", at, 122);
      check_outs("p1", 8'h81, 8'h81, 8'h00, 1'b1);

      // second poll 8'h03
      m_data = 8'h03;
      wait_sig(0, 120, at);  check("p2.start_cyc", at, 201);
      wait_sig(1, 40, at);   check("p2.upd_cyc", at, 222);
      check_outs("p2", 8'h03, 8'h02, 8'h80, 1'b1);
      @(negedge clk);
      check("p2.upd_drop", 32'(update), 32'd0);
      check_outs("p2.next", 8'h03, 8'h00, 8'h00, 1'b1);

      // bridge stays busy past the timeout; late ready carries junk data
      m_delay = 60; m_data = 8'hFF; m_valid = 1'b1;
      wait_sig(0, 120, at);  check("t1.start_cyc", at, 301);
      wait_sig(1, 98, at);   check("t1.no_upd", at, -1);
      check("t1.buttons", 32'(buttons), 32'h03);
      wait_sig(0, 10, at);   check("t2.start_cyc", at, 401);
      wait_sig(1, 98, at);   check("t2.no_upd", at, -1);
      check("t2.connected", 32'(connected), 32'd1);
      wait_sig(0, 10, at);   check("t3.start_cyc", at, 501);
      wait_sig(1, 60, at);   check("t3.upd_cyc", at, 552);
      check_outs("t3", 8'h00, 8'h00, 8'h03, 1'b0);
      wait_sig(1, 40, at);   check("t3.late_ignored", at, -1);
      check("t3.buttons_hold", 32'(buttons), 32'h00);

      // reconnect, one invalid completion, then 8'h10
      m_delay = 20; m_data = 8'h03; m_valid = 1'b1;
      wait_sig(0, 20, at);   check("v1.start_cyc", at, 601);
      wait_sig(1, 40, at);   check("v1.upd_cyc", at, 622);
      check_outs("v1", 8'h03, 8'h03, 8'h00, 1'b1);
      m_valid = 1'b0;
      wait_sig(0, 100, at);  check("v2.start_cyc", at, 701);
      wait_sig(1, 98, at);   check("v2.no_upd", at, -1);
      check_outs("v2", 8'h03, 8'h00, 8'h00, 1'b1);
      m_valid = 1'b1; m_data = 8'h10;
      wait_sig(0, 10, at);   check("v3.start_cyc", at, 801);
      wait_sig(1, 40, at);   check("v3.upd_cyc", at, 822);
      check_outs("v3", 8'h10, 8'h10, 8'h03, 1'b1);
      // two more fails must not disconnect if the success cleared the count
      m_valid = 1'b0;
      wait_sig(0, 100, at);  check("v4.start_cyc", at, 901);
      wait_sig(1, 98, at);   check("v4.no_upd", at, -1);
      wait_sig(0, 10, at);   check("v5.start_cyc", at, 1001);
      wait_sig(1, 98, at);   check("v5.no_upd", at, -1);
      check_outs("v5", 8'h10, 8'h00, 8'h00, 1'b1);

      // enable drops during BUSY: transaction still completes once
      m_valid = 1'b1; m_data = 8'h55;
      wait_sig(0, 10, at);   check("e1.start_cyc", at, 1101);
      @(negedge clk);
      enable = 1'b0;
      wait_sig(1, 40, at);   check("e1.upd_cyc", at, 1122);
      check_outs("e1", 8'h55, 8'h45, 8'h00, 1'b1);
      wait_sig(0, 500, at);  check("e1.no_start", at, -1);
      e = cyc;
      enable = 1'b1;
      wait_sig(0, 150, at);  check("e2.start_delta", at - e, 101);
      wait_sig(1, 40, at);   check("e2.upd_delta", at - e, 122);
      check_outs("e2", 8'h55, 8'h00, 8'h00, 1'b1);

      // asynchronous reset mid-BUSY, between clock edges
      wait_sig(0, 120, at);  check("r.start_delta", at - e, 201);
      repeat (5) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check_outs("r.async", 8'h00, 8'h00, 8'h00, 1'b0);
      check("r.update", 32'(update), 32'd0);
      check("r.start", 32'(bridge_start), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      wait_sig(0, 150, at);  check("r2.start_cyc", at, 101);
      wait_sig(1, 40, at);   check("r2.upd_cyc", at, 122);
      check_outs("r2", 8'h55, 8'h55, 8'h00, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/joypad_poller.md
# joypad_poller

Fixed-rate scheduler that sequences the NES-controller I2C bridge. It issues one bridge transaction per poll period and supervises each one with a timeout. It holds the last good button state and emits one-cycle pressed/released masks plus an update strobe to game logic. It sits between `nes_bridge`, which is instantiated beside it at top level, and the game core.

## Interface
- `POLL_PERIOD`, 833_333: cycles between poll ticks (60 Hz at 50 MHz); ≥ 2.
- `TIMEOUT`, 2_000_000: max cycles a transaction may stay outstanding; ≥ 2.
- `FAIL_LIMIT`, 3: consecutive failed polls that declare the controller disconnected; ≥ 1.
- `clk` in 1: system clock.
- `rst` in 1: reset; **one clock; reset is asynchronous and active-high**.
- `enable` in 1: allow new polls.
- `bridge_start` out 1: one-cycle start request to the bridge.
- `bridge_ready` in 1: bridge idle.
- `bridge_joypad` in 8: bridge button byte.
- `bridge_valid` in 1: bridge byte valid.
- `buttons` out 8: last accepted button state; 1 = held.
- `pressed` out 8: 0→1 mask; nonzero only in the `update` cycle.
- `released` out 8: 1→0 mask; nonzero only in the `update` cycle.
- `update` out 1: one-cycle strobe on every `buttons` change attempt (success or disconnect).
- `connected` out 1: controller answering.

## Operation
- Tick generator:
  - Counter runs 0..POLL_PERIOD-1 while `enable`=1 and emits `tick` on wrap.
  - `enable`=0 holds the counter at 0 and clears `pending`.
- `pending` is set by `tick` and cleared when `bridge_start` fires. Ticks arriving while `pending`=1 collapse into one.
- States:
  - IDLE: `pending`=1 → ISSUE.
  - ISSUE: `bridge_start`=`bridge_ready`, combinational from the state. Fires when ready=1 → BUSY with the timeout counter cleared and `seen_busy`=0.
    - If `enable` drops while in ISSUE before the start fires → IDLE.
  - BUSY:
    - Sets `seen_busy` on `bridge_ready`=0; the timeout counter increments every cycle.
    - `seen_busy`=1 and `bridge_ready`=1 → complete → IDLE.
    - Counter reaches TIMEOUT-1 without completion → fail → IDLE.
    - Completion and timeout in the same cycle: completion wins.
- Complete with `bridge_valid`=1 (success):
  - `buttons`←`bridge_joypad`.
  - `pressed`←new & ~old; `released`←~new & old; `update`=1.
  - Fail counter←0; `connected`←1.
- Complete with `bridge_valid`=0, or timeout (fail):
  - Fail counter increments and saturates at FAIL_LIMIT.
  - `buttons` holds while the count is below FAIL_LIMIT.
  - On the transition to FAIL_LIMIT: `connected`←0, `released`←old `buttons`, `buttons`←0, `pressed`←0, `update`=1.
  - Further fails produce no `update`.
- After a timeout the bridge may still be busy; the next ISSUE waits for `bridge_ready`. A late completion from the abandoned transaction is ignored, because no state other than BUSY observes the bridge.
- `enable`=0 during BUSY: the transaction completes or times out normally; no new start is issued.

## Timing
- Reset values: all outputs 0, `connected`=0, state IDLE, all counters 0, `pending`=0.
- Reset asserted mid-transaction returns everything to reset values immediately. The bridge is reset separately at top level.
- Latency:
  - `tick`→`bridge_start`: 2 cycles when the bridge is ready (tick sets `pending`; IDLE→ISSUE; start in ISSUE).
  - Completion cycle→`update`/`buttons` valid: 1 cycle (all outputs registered).
- `bridge_start` is high for exactly one cycle per transaction and never while `bridge_ready`=0.
- `pressed`/`released` return to 0 the cycle after `update`.
- `update` with `pressed`=`released`=0 is legal (unchanged state).
- Counter widths: `$clog2(param+1)`; the timeout counter saturates.

## Structure
- Shared package `joypad_pkg`:
  - State encoding (IDLE, ISSUE, BUSY).
  - Default POLL_PERIOD/TIMEOUT/FAIL_LIMIT constants.
  - Button bit-index constants (A, B, SELECT, START, UP, DOWN, LEFT, RIGHT) matching the bridge's `joypad` packing.
- Sub-module `tick_gen`: a parameterised period counter with enable and one-cycle `tick` output.

## Test plan
All scenarios use POLL_PERIOD=100, TIMEOUT=50, FAIL_LIMIT=3, with a behavioural bridge model that drops ready 1 cycle after start and completes after 20 cycles.
- Reset, `enable`=1, model returns 8'h81:
  - `bridge_start` fires 2 cycles after the first tick.
  - `update` follows with `buttons`=8'h81, `pressed`=8'h81, `connected`=1.
- Next poll returns 8'h03:
  - `pressed`=8'h02, `released`=8'h80, `buttons`=8'h03.
  - Both masks are 0 one cycle later.
- Model never re-asserts ready:
  - Fail at BUSY cycle 50, with no `update` for the first two fails.
  - Third fail: `connected`=0, `released`=8'h03, `buttons`=0.
- Model completes with `bridge_valid`=0 once, then valid 8'h10:
  - The fail does not change `buttons`.
  - Success resets the fail count; `connected` stays 1.
- `enable` drops during BUSY:
  - The transaction completes and updates once.
  - No further `bridge_start` for 500 cycles.
  - Re-enable: next start is 101 cycles later.
- `rst` pulsed mid-BUSY (asynchronous, between edges):
  - All outputs read 0 before the next clock edge.
  - Polling restarts cleanly after release.
